// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipe_stage_reg slice
package pipe_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 7;
  localparam int CNT_W      = 32;

  typedef logic [1:0] occ_t;

  function automatic occ_t occ_of(input logic main_v, input logic skid_v);
    return occ_t'({1'b0, main_v}) + occ_t'({1'b0, skid_v});
  endfunction
endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - upstream/downstream valid-ready bundle for pipe_stage_reg
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) ();
  logic              up_valid;
  logic              up_ready;
  logic [DATA_W-1:0] up_data;
  logic [CTRL_W-1:0] up_ctrl;
  logic              dn_valid;
  logic              dn_ready;
  logic [DATA_W-1:0] dn_data;
  logic [CTRL_W-1:0] dn_ctrl;

  modport slave (
    input  up_valid, up_data, up_ctrl, dn_ready,
    output up_ready, dn_valid, dn_data, dn_ctrl
  );

  modport master (
    output up_valid, up_data, up_ctrl, dn_ready,
    input  up_ready, dn_valid, dn_data, dn_ctrl
  );
endinterface

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one pipeline holding slot: valid bit plus payload/control register
module pipe_slot #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);
  // Clear kills the control flags but keeps the payload, so a bubble never carries write enables.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= in_data;
      ctrl  <= in_ctrl;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - skid-buffered pipeline stage register; PIPE_STAGE_PERF_CNT_EN enables bubble counter
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  pipe_stage_reg_if.slave      bus,
  output occ_t                 occupancy,
  output logic [CNT_W-1:0]     bubble_count
);
  logic              main_v, skid_v;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              accept, main_adv;
  logic              main_load, main_clear, skid_load, skid_clear;
  logic [DATA_W-1:0] main_in_data;
  logic [CTRL_W-1:0] main_in_ctrl;

  // up_ready comes straight from the skid flop, keeping dn_ready off the upstream path.
  assign bus.up_ready = ~skid_v;
  assign accept       = bus.up_valid & ~skid_v;
  assign main_adv     = bus.dn_ready | ~main_v;

  always_comb begin
    main_load    = 1'b0;
    main_clear   = 1'b0;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    main_in_data = bus.up_data;
    main_in_ctrl = bus.up_ctrl;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (main_adv) begin
      if (skid_v) begin
        main_load    = 1'b1;
        skid_clear   = 1'b1;
        main_in_data = skid_data;
        main_in_ctrl = skid_ctrl;
      end else if (accept) begin
        main_load = 1'b1;
      end else begin
        main_clear = 1'b1;
      end
    end else if (accept) begin
      skid_load = 1'b1;
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clock(clock), .reset(reset), .load(main_load), .clear(main_clear),
    .in_data(main_in_data), .in_ctrl(main_in_ctrl),
    .valid(main_v), .data(main_data), .ctrl(main_ctrl)
  );

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clock(clock), .reset(reset), .load(skid_load), .clear(skid_clear),
    .in_data(bus.up_data), .in_ctrl(bus.up_ctrl),
    .valid(skid_v), .data(skid_data), .ctrl(skid_ctrl)
  );

  assign bus.dn_valid = main_v;
  assign bus.dn_data  = main_data;
  assign bus.dn_ctrl  = main_ctrl;
  assign occupancy    = occ_of(main_v, skid_v);

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] bubble_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      bubble_q <= '0;
    end else if (bus.dn_ready && !main_v && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_q <= bubble_q + 1'b1;
    end
  end

  assign bubble_count = bubble_q;
`else
  assign bubble_count = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized and directed checks of pipe_stage_reg against a FIFO model
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  typedef struct {
    logic [31:0] d;
    logic [6:0]  c;
  } ent_t;

  logic        clock;
  logic        reset;
  logic        flush;
  occ_t        occupancy;
  logic [31:0] bubble_count;

  pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(7)) bus ();

  pipe_stage_reg dut (
    .clock(clock), .reset(reset), .flush(flush), .bus(bus),
    .occupancy(occupancy), .bubble_count(bubble_count)
  );

  int errors = 0;
  int checks = 0;

  ent_t        q[$];
  logic [31:0] m_data;
  logic [31:0] m_bub;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: the stage is a 2-deep FIFO whose head is dn_*; it accepts only while fewer than 2 are held.
  task automatic step(input logic uv, input logic [31:0] ud, input logic [6:0] uc,
                      input logic dr, input logic fl, input logic rs);
    bit can;
    ent_t e;
    bus.up_valid = uv;
    bus.up_data  = ud;
    bus.up_ctrl  = uc;
    bus.dn_ready = dr;
    flush        = fl;
    reset        = rs;
    if (!rs) begin
      q.delete();
      m_data = 32'h0;
      m_bub  = 32'h0;
    end else begin
      if (dr && q.size() == 0 && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
      if (fl) begin
        q.delete();
      end else begin
        can = (q.size() < 2);
        if (dr && q.size() > 0) void'(q.pop_front());
        if (uv && can) begin
          e.d = ud;
          e.c = uc;
          q.push_back(e);
        end
      end
      if (q.size() > 0) m_data = q[0].d;
    end
    @(posedge clock);
    @(negedge clock);
    check("dn_valid", 32'(bus.dn_valid), 32'(q.size() > 0));
    if (q.size() > 0) check("dn_ctrl", 32'(bus.dn_ctrl), 32'(q[0].c));
    else              check("dn_ctrl_bubble", 32'(bus.dn_ctrl), 32'h0);
    check("dn_data", bus.dn_data, m_data);
    check("up_ready", 32'(bus.up_ready), 32'(q.size() < 2));
    check("occupancy", 32'(occupancy), 32'(q.size()));
`ifdef PIPE_STAGE_PERF_CNT_EN
    check("bubble_count", bubble_count, m_bub);
`else
    check("bubble_count", bubble_count, 32'h0);
`endif
  endtask

  initial begin
    bus.up_valid = 1'b0;
    bus.up_data  = '0;
    bus.up_ctrl  = '0;
    bus.dn_ready = 1'b0;
    flush        = 1'b0;
    reset        = 1'b0;
    m_data       = 32'h0;
    m_bub        = 32'h0;
    @(negedge clock);

    step(1'b1, 32'hDEAD_BEEF, 7'h7F, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 7'h0, 1'b0, 1'b0, 1'b0);

    // Single transfer lands one cycle later
    step(1'b1, 32'h0000_0040, 7'h33, 1'b1, 1'b0, 1'b1);
    check("single_data", bus.dn_data, 32'h40);
    check("single_ctrl", 32'(bus.dn_ctrl), 32'h33);
    check("single_occ", 32'(occupancy), 32'd1);
    step(1'b0, 32'h0, 7'h0, 1'b1, 1'b0, 1'b1);

    // A, B, C against a stalled downstream, then drain
    step(1'b1, 32'hA, 7'h0A, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hB, 7'h0B, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hC, 7'h0C, 1'b0, 1'b0, 1'b1);
    check("stall_head", bus.dn_data, 32'hA);
    check("stall_ready", 32'(bus.up_ready), 32'd0);
    step(1'b1, 32'hC, 7'h0C, 1'b1, 1'b0, 1'b1);
    check("drain_b", bus.dn_data, 32'hB);
    step(1'b1, 32'hC, 7'h0C, 1'b1, 1'b0, 1'b1);
    check("drain_c", bus.dn_data, 32'hC);
    step(1'b0, 32'h0, 7'h0, 1'b1, 1'b0, 1'b1);

    // Flush while full with a new entry offered
    step(1'b1, 32'h11, 7'h11, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h22, 7'h22, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h99, 7'h59, 1'b0, 1'b1, 1'b1);
    check("flush_occ", 32'(occupancy), 32'd0);
    check("flush_ready", 32'(bus.up_ready), 32'd1);
    step(1'b0, 32'h0, 7'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 7'h0, 1'b1, 1'b0, 1'b1);

    // Five idle cycles after reset
    step(1'b0, 32'h0, 7'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 7'h0, 1'b1, 1'b0, 1'b1);
`ifdef PIPE_STAGE_PERF_CNT_EN
    check("idle_bubbles", bubble_count, 32'd5);
`else
    check("idle_bubbles", bubble_count, 32'd0);
`endif

    // Reset while full and stalled
    step(1'b1, 32'h33, 7'h13, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h44, 7'h14, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h55, 7'h15, 1'b0, 1'b1, 1'b0);
    check("rst_data", bus.dn_data, 32'h0);
    check("rst_ready", 32'(bus.up_ready), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 7'h0, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 7'($urandom_range(0, 127)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 63) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
